// File: rtl/operand_stage.sv
// operand_stage: selects source operands, sign-extends the immediate and registers the decoded fields.
// Latency: one cycle from accept to OutValid; one instruction per cycle when no hazard is present.
// Backpressure: InReady drops on a load-use hazard or while FULL with OutReady=0; held outputs stay stable.
// Build option OPERAND_STAGE_FORWARD_EN: write-back bypass on, load tracker window 2 cycles;
// undefined: no bypass, tracker window 3 cycles, and a live write-back to a source also stalls.
module operand_stage (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        InValid,
    output logic        InReady,
    input  logic [4:0]  InRs,
    input  logic [4:0]  InRt,
    input  logic [4:0]  InDest,
    input  logic [15:0] InImm,
    input  logic        InIsLoad,
    input  logic        InRegWrite,
    output logic [4:0]  RegRead1,
    output logic [4:0]  RegRead2,
    input  logic [31:0] RegData1,
    input  logic [31:0] RegData2,
    input  logic        WbRegWrite,
    input  logic [4:0]  WbReg,
    input  logic [31:0] WbData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutA,
    output logic [31:0] OutB,
    output logic [31:0] OutImm,
    output logic [4:0]  OutDest,
    output logic        OutIsLoad,
    output logic        OutRegWrite
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

`ifdef OPERAND_STAGE_FORWARD_EN
    // Load data is bypassed in its write-back cycle, so only two post-transfer cycles stall.
    localparam logic [1:0] PEND_RELOAD = 2'd2;
`else
    // Without bypass the dependent must wait until the register file holds the load data.
    localparam logic [1:0] PEND_RELOAD = 2'd3;
`endif

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        xfer;
    logic        load_out;
    logic        arm;
    logic        hit_rs;
    logic        hit_rt;
    logic        hazard;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  pend_dest;
    logic [1:0]  pend_cnt;

    assign RegRead1 = InRs;
    assign RegRead2 = InRt;
    assign OutValid = (state == FULL);
    assign xfer     = OutValid & OutReady;
    assign load_out = OutValid & OutIsLoad & OutRegWrite;
    // Destination 0 is never written, so it never arms the tracker.
    assign arm      = xfer & OutIsLoad & OutRegWrite & (OutDest != 5'd0);
    assign InReady  = ~hazard & (~OutValid | OutReady);
    assign accept   = InValid & InReady;

    // Hazard detection: a nonzero source that matches a load still in flight.
    always_comb begin
        hit_rs = (load_out && (OutDest == InRs)) || ((pend_cnt != 2'd0) && (pend_dest == InRs));
        hit_rt = (load_out && (OutDest == InRt)) || ((pend_cnt != 2'd0) && (pend_dest == InRt));
`ifdef OPERAND_STAGE_FORWARD_EN
`else
        hit_rs = hit_rs || (WbRegWrite && (WbReg == InRs));
        hit_rt = hit_rt || (WbRegWrite && (WbReg == InRt));
`endif
        hazard = InValid && (((InRs != 5'd0) && hit_rs) || ((InRt != 5'd0) && hit_rt));
    end

`ifdef OPERAND_STAGE_FORWARD_EN
    // Operand select: register 0 reads as zero, then write-back bypass, then register file.
    always_comb begin
        op_a = RegData1;
        op_b = RegData2;
        if (WbRegWrite && (WbReg == InRs)) op_a = WbData;
        if (WbRegWrite && (WbReg == InRt)) op_b = WbData;
        if (InRs == 5'd0) op_a = '0;
        if (InRt == 5'd0) op_b = '0;
    end
`else
    // The write-back data path is not consumed in this build.
    logic unused_wb_data;
    assign unused_wb_data = ^WbData;

    // Operand select: register 0 reads as zero, otherwise register file only.
    always_comb begin
        op_a = RegData1;
        op_b = RegData2;
        if (InRs == 5'd0) op_a = '0;
        if (InRt == 5'd0) op_b = '0;
    end
`endif

    // Next-state logic for the output holding register.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (accept) state_next = FULL;
                     else if (OutReady) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Output state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= EMPTY;
        else          state <= state_next;
    end

    // Output payload loads only on accept, so a stalled FULL output stays stable.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            OutA        <= '0;
            OutB        <= '0;
            OutImm      <= '0;
            OutDest     <= '0;
            OutIsLoad   <= 1'b0;
            OutRegWrite <= 1'b0;
        end else if (accept) begin
            OutA        <= op_a;
            OutB        <= op_b;
            OutImm      <= {{16{InImm[15]}}, InImm};
            OutDest     <= InDest;
            OutIsLoad   <= InIsLoad;
            OutRegWrite <= InRegWrite;
        end
    end

    // Load-use tracker: arms when a load leaves, then counts down toward its write-back.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_dest <= '0;
            pend_cnt  <= '0;
        end else if (arm) begin
            pend_dest <= OutDest;
            pend_cnt  <= PEND_RELOAD;
        end else if (pend_cnt != 2'd0) begin
            pend_cnt  <= pend_cnt - 2'd1;
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// tb_operand_stage: table-driven vectors plus hand sequences for hazards, stalls and reset.
// Expected outputs are queued on accept and compared when the output transfers.
// Works in both builds; stall counts and bypass expectations follow OPERAND_STAGE_FORWARD_EN.
module tb_operand_stage;

`ifdef OPERAND_STAGE_FORWARD_EN
    localparam int STALLS = 3;
`else
    localparam int STALLS = 4;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        InValid;
    logic        InReady;
    logic [4:0]  InRs, InRt, InDest;
    logic [15:0] InImm;
    logic        InIsLoad, InRegWrite;
    logic [4:0]  RegRead1, RegRead2;
    logic [31:0] RegData1, RegData2;
    logic        WbRegWrite;
    logic [4:0]  WbReg;
    logic [31:0] WbData;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutA, OutB, OutImm;
    logic [4:0]  OutDest;
    logic        OutIsLoad, OutRegWrite;

    operand_stage dut (
        .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
        .InRs(InRs), .InRt(InRt), .InDest(InDest), .InImm(InImm),
        .InIsLoad(InIsLoad), .InRegWrite(InRegWrite),
        .RegRead1(RegRead1), .RegRead2(RegRead2), .RegData1(RegData1), .RegData2(RegData2),
        .WbRegWrite(WbRegWrite), .WbReg(WbReg), .WbData(WbData),
        .OutValid(OutValid), .OutReady(OutReady), .OutA(OutA), .OutB(OutB), .OutImm(OutImm),
        .OutDest(OutDest), .OutIsLoad(OutIsLoad), .OutRegWrite(OutRegWrite)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic        ld;
        logic        rw;
    } out_t;

    typedef struct {
        logic [4:0]  rs, rt, dest;
        logic [15:0] imm;
        logic        ld, rw;
        logic [31:0] rd1, rd2;
        logic [31:0] ea, eb, eimm;
    } vec_t;

    out_t sb[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                                input logic [15:0] imm, input logic ld, input logic rw,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] eimm);
        vec_t v;
        v.rs = rs; v.rt = rt; v.dest = dest; v.imm = imm; v.ld = ld; v.rw = rw;
        v.rd1 = rd1; v.rd2 = rd2; v.ea = ea; v.eb = eb; v.eimm = eimm;
        return v;
    endfunction

    function automatic out_t exp_of(input vec_t v);
        out_t o;
        o.a = v.ea; o.b = v.eb; o.imm = v.eimm; o.dest = v.dest; o.ld = v.ld; o.rw = v.rw;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Advance to the falling edge and score any output that transfers on the next rising edge.
    task automatic mon_step();
        out_t got;
        out_t e;
        @(negedge Clk);
        if (OutValid && OutReady) begin
            got.a = OutA; got.b = OutB; got.imm = OutImm;
            got.dest = OutDest; got.ld = OutIsLoad; got.rw = OutRegWrite;
            chk_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL out_unexpected: output a=%h with nothing expected", OutA);
            end else begin
                e = sb.pop_front();
                if (got === e) pass_cnt++;
                else $display("FAIL out_data: got a=%h b=%h imm=%h dest=%0d ld=%b rw=%b expected a=%h b=%h imm=%h dest=%0d ld=%b rw=%b",
                              got.a, got.b, got.imm, got.dest, got.ld, got.rw, e.a, e.b, e.imm, e.dest, e.ld, e.rw);
            end
        end
    endtask

    task automatic drive(input vec_t v);
        InValid = 1'b1; InRs = v.rs; InRt = v.rt; InDest = v.dest; InImm = v.imm;
        InIsLoad = v.ld; InRegWrite = v.rw; RegData1 = v.rd1; RegData2 = v.rd2;
    endtask

    // Present one instruction until accepted; reports how many cycles it waited.
    task automatic send(input vec_t v, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        drive(v);
        for (int k = 0; k < 16 && !ok; k++) begin
            mon_step();
            if (k == 0) begin
                check("rd_addr1", 32'(RegRead1), 32'(v.rs));
                check("rd_addr2", 32'(RegRead2), 32'(v.rt));
            end
            if (InReady) begin
                sb.push_back(exp_of(v));
                ok = 1'b1;
            end else begin
                waited++;
            end
            @(posedge Clk); #1;
        end
        InValid = 1'b0;
        if (!ok) begin
            chk_cnt++;
            $display("FAIL send_timeout: InReady=0 for 16 cycles, required acceptance");
        end
    endtask

    task automatic drain();
        InValid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (sb.size() == 0 && !OutValid) break;
            mon_step();
            @(posedge Clk); #1;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        vec_t v, ld7, dep, va, vb, l9, d9;
        int   w;
        bit   ok;

        Reset_n = 1'b1; InValid = 1'b0; InRs = '0; InRt = '0; InDest = '0; InImm = '0;
        InIsLoad = 1'b0; InRegWrite = 1'b0; RegData1 = '0; RegData2 = '0;
        WbRegWrite = 1'b0; WbReg = '0; WbData = '0; OutReady = 1'b1;

        // Reset values
        #1 Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_valid", 32'(OutValid), 32'd0);
        check("rst_a", OutA, 32'd0);
        check("rst_b", OutB, 32'd0);
        check("rst_imm", OutImm, 32'd0);
        check("rst_dest", 32'(OutDest), 32'd0);
        check("rst_ld", 32'(OutIsLoad), 32'd0);
        check("rst_rw", 32'(OutRegWrite), 32'd0);
        @(posedge Clk); #1 Reset_n = 1'b1;

        // Back-to-back vectors: operand read, zero register, immediate sign extension
        tbl[0] = mk(5'd3,  5'd4, 5'd2,  16'h0001, 1'b0, 1'b1, 32'h11, 32'h22, 32'h11, 32'h22, 32'h0000_0001);
        tbl[1] = mk(5'd6,  5'd7, 5'd3,  16'h8000, 1'b0, 1'b1, 32'h1, 32'h2, 32'h1, 32'h2, 32'hFFFF_8000);
        tbl[2] = mk(5'd8,  5'd9, 5'd4,  16'h7FFF, 1'b0, 1'b1, 32'h3, 32'h4, 32'h3, 32'h4, 32'h0000_7FFF);
        tbl[3] = mk(5'd0,  5'd5, 5'd6,  16'h0100, 1'b0, 1'b1, 32'h55, 32'h66, 32'h0, 32'h66, 32'h0000_0100);
        tbl[4] = mk(5'd31, 5'd0, 5'd1,  16'hFF00, 1'b0, 1'b1, 32'hA5A5A5A5, 32'h1234, 32'hA5A5A5A5, 32'h0, 32'hFFFF_FF00);
        tbl[5] = mk(5'd10, 5'd11, 5'd31, 16'hFFFF, 1'b0, 1'b0, 32'h77, 32'h88, 32'h77, 32'h88, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin
            send(tbl[i], w);
            check($sformatf("tbl%0d_wait", i), 32'(w), 32'd0);
        end
        drain();

        // Write-back port presented while reading register 5
        WbRegWrite = 1'b1; WbReg = 5'd5; WbData = 32'hDEADBEEF;
`ifdef OPERAND_STAGE_FORWARD_EN
        v = mk(5'd5, 5'd0, 5'd3, 16'h0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);
        send(v, w);
        check("byp_wait", 32'(w), 32'd0);
`else
        v = mk(5'd5, 5'd0, 5'd3, 16'h0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);
        drive(v);
        mon_step();
        check("wbhaz_rdy", 32'(InReady), 32'd0);
        @(posedge Clk); #1;
        WbRegWrite = 1'b0;
        v.rd1 = 32'hDEADBEEF;
        send(v, w);
        check("wbhaz_wait", 32'(w), 32'd0);
        WbRegWrite = 1'b1;
`endif
        WbReg = 5'd0;
        v = mk(5'd0, 5'd0, 5'd3, 16'h0, 1'b0, 1'b1, 32'h9, 32'h9, 32'h0, 32'h0, 32'h0);
        send(v, w);
        check("zero_wait", 32'(w), 32'd0);
        WbRegWrite = 1'b0;
        drain();

        // Load followed by a dependent instruction
        ld7 = mk(5'd1, 5'd2, 5'd7, 16'h0, 1'b1, 1'b1, 32'h101, 32'h202, 32'h101, 32'h202, 32'h0);
        dep = mk(5'd7, 5'd0, 5'd8, 16'h4, 1'b0, 1'b1, 32'h0, 32'h0, 32'hCAFE0007, 32'h0, 32'h4);
        send(ld7, w);
        drive(dep);
        ok = 1'b0;
        for (int k = 0; k <= STALLS && !ok; k++) begin
            WbRegWrite = (k == 3); WbReg = 5'd7; WbData = 32'hCAFE0007;
            RegData1 = (k >= 4) ? 32'hCAFE0007 : 32'h0;
            mon_step();
            check($sformatf("lu_rdy%0d", k), 32'(InReady), 32'(k == STALLS));
            if (InReady) begin
                sb.push_back(exp_of(dep));
                ok = 1'b1;
            end
            @(posedge Clk); #1;
        end
        InValid = 1'b0; WbRegWrite = 1'b0;
        if (!ok) begin
            chk_cnt++;
            $display("FAIL lu_timeout: dependent not accepted within %0d cycles", STALLS + 1);
        end
        drain();

        // Output stalled while FULL, then asynchronous reset
        va = mk(5'd3, 5'd4, 5'd5, 16'h8001, 1'b0, 1'b1, 32'h33, 32'h44, 32'h33, 32'h44, 32'hFFFF8001);
        vb = mk(5'd6, 5'd9, 5'd10, 16'h1, 1'b0, 1'b1, 32'h1, 32'h2, 32'h1, 32'h2, 32'h1);
        send(va, w);
        OutReady = 1'b0;
        drive(vb);
        for (int k = 0; k < 4; k++) begin
            mon_step();
            check($sformatf("stall_valid%0d", k), 32'(OutValid), 32'd1);
            check($sformatf("stall_rdy%0d", k), 32'(InReady), 32'd0);
            check($sformatf("stall_a%0d", k), OutA, 32'h33);
            check($sformatf("stall_imm%0d", k), OutImm, 32'hFFFF8001);
            @(posedge Clk); #1;
        end
        #2 Reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(OutValid), 32'd0);
        check("arst_a", OutA, 32'd0);
        check("arst_imm", OutImm, 32'd0);
        sb.delete();
        InValid = 1'b0; OutReady = 1'b1;
        @(posedge Clk); #1 Reset_n = 1'b1;
        @(negedge Clk);
        check("arst_hold", 32'(OutValid), 32'd0);
        @(posedge Clk); #1;

        // Reset while a load is pending clears the tracker
        l9 = mk(5'd1, 5'd2, 5'd9, 16'h0, 1'b1, 1'b1, 32'h5, 32'h6, 32'h5, 32'h6, 32'h0);
        d9 = mk(5'd9, 5'd0, 5'd4, 16'h0, 1'b0, 1'b1, 32'h99, 32'h0, 32'h99, 32'h0, 32'h0);
        send(l9, w);
        mon_step();
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        #2 Reset_n = 1'b1;
        send(d9, w);
        check("rst_pend_wait", 32'(w), 32'd0);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
